// File: rtl/cpu_ctrl.sv
// cpu_ctrl: multi-cycle control unit for the 9-bit datapath.
// Fetches instructions over a req/ack handshake, decodes them into ALU and
// register-file controls, then sequences execute and writeback. Every output
// is a flop; the output flops are loaded from the next-state value so they
// line up with the state they describe.
module cpu_ctrl (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    output logic       imem_req,
    input  logic       imem_ack,
    input  logic [8:0] imem_rdata,
    output logic       pc_inc,
    output logic [1:0] rf_ra_a,
    output logic [1:0] rf_ra_b,
    output logic [1:0] rf_wa,
    output logic       rf_we,
    output logic [3:0] alu_opcode,
    output logic       alu_bsel_imm,
    output logic [8:0] imm,
    output logic       busy,
    output logic       halted,
    output logic       illegal
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_NOT  = 4'd2;
    localparam logic [3:0] OP_ADD  = 4'd3;
    localparam logic [3:0] OP_MOV  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SUB  = 4'd7;
    localparam logic [3:0] OP_ADDI = 4'd8;
    localparam logic [3:0] OP_SUBI = 4'd9;
    localparam logic [3:0] OP_MOVI = 4'd10;
    localparam logic [3:0] OP_NOP  = 4'd11;
    localparam logic [3:0] OP_HALT = 4'd15;

    // Decoded view of one instruction word; registered as a group.
    typedef struct packed {
        logic [1:0] ra_a;
        logic [1:0] ra_b;
        logic [1:0] wa;
        logic [3:0] opcode;
        logic       bsel;
        logic [8:0] imm;
        logic       illegal;
    } decode_t;

    state_t  state;
    state_t  next_state;
    decode_t dec;
    logic    fetch_done;

    // An ack only counts while a fetch is outstanding.
    assign fetch_done = (state == S_FETCH) && imem_ack;

    // Decode the instruction word currently on the memory bus.
    always_comb begin
        // NOTE: every field gets a default before the case so no path can
        // leave a variable unassigned and infer a latch.
        dec         = '0;
        dec.opcode  = imem_rdata[8:5];
        dec.wa      = imem_rdata[4:3];
        dec.ra_a    = imem_rdata[4:3];
        dec.ra_b    = imem_rdata[2:1];
        dec.imm     = {6'b0, imem_rdata[2:0]};
        case (imem_rdata[8:5])
            OP_AND, OP_OR, OP_ADD, OP_SUB: begin
                dec.bsel = 1'b0;
            end
            OP_NOT, OP_MOV, OP_SLL, OP_SRL: begin
                // Single-operand ops take their source from rs on port a.
                dec.ra_a = imem_rdata[2:1];
            end
            OP_ADDI, OP_SUBI, OP_MOVI: begin
                dec.bsel = 1'b1;
            end
            OP_NOP, OP_HALT: begin
                dec.bsel = 1'b0;
            end
            default: begin
                // 12..14 are undefined; they flow through as a NOP.
                dec.illegal = 1'b1;
            end
        endcase
    end

    // Next-state selection; DECODE branches on the opcode latched at the ack.
    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE:   if (start) next_state = S_FETCH;
            S_FETCH:  if (imem_ack) next_state = S_DECODE;
            S_DECODE: begin
                if (alu_opcode == OP_HALT) begin
                    next_state = S_HALT;
                end else if (alu_opcode == OP_NOP || alu_opcode == 4'd12 ||
                             alu_opcode == 4'd13 || alu_opcode == 4'd14) begin
                    next_state = S_FETCH;
                end else begin
                    next_state = S_EXEC;
                end
            end
            S_EXEC:   next_state = S_WB;
            S_WB:     next_state = S_FETCH;
            S_HALT:   next_state = S_HALT;
            default:  next_state = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Handshake, pulse and status flops, derived from the state being entered.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: every control flop is reset so an abandoned instruction can
        // never leave a stray rf_we, pc_inc or imem_req behind.
        if (reset) begin
            imem_req <= 1'b0;
            pc_inc   <= 1'b0;
            illegal  <= 1'b0;
            rf_we    <= 1'b0;
            busy     <= 1'b0;
            halted   <= 1'b0;
        end else begin
            imem_req <= (next_state == S_FETCH);
            pc_inc   <= fetch_done;
            illegal  <= fetch_done && dec.illegal;
            rf_we    <= (next_state == S_WB);
            busy     <= (next_state != S_IDLE) && (next_state != S_HALT);
            halted   <= (next_state == S_HALT);
        end
    end

    // Instruction register: the decoded fields load only on the ack edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rf_ra_a      <= 2'd0;
            rf_ra_b      <= 2'd0;
            rf_wa        <= 2'd0;
            alu_opcode   <= 4'd0;
            alu_bsel_imm <= 1'b0;
            imm          <= 9'd0;
        end else if (fetch_done) begin
            rf_ra_a      <= dec.ra_a;
            rf_ra_b      <= dec.ra_b;
            rf_wa        <= dec.wa;
            alu_opcode   <= dec.opcode;
            alu_bsel_imm <= dec.bsel;
            imm          <= dec.imm;
        end
    end

endmodule
